// File: rtl/mc_seq.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with variable-latency imem/dmem handshakes.
// Build option MC_ILLEGAL_TRAP_EN: an illegal opcode parks in TRAP (sticky illegal) instead of retiring as a NOP.
module mc_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  Op,
  input  logic        RegWrite_d,
  input  logic        MemWrite_d,
  input  logic        MemRead_d,
  input  logic        sbtype,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic        Zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic [2:0]  npc_sel,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5,
    S_RST  = 3'd6
  } state_t;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  endfunction

  // Strobes depend only on state plus this cycle's inputs, so the async reset
  // forcing S_RST also drops every request and strobe in the same cycle.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_PLUS4;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (op_legal(Op)) begin
          state_d = S_EX;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d   = S_TRAP;
          illegal_d = 1'b1;
`else
          pc_we   = 1'b1;
          state_d = S_IF;
`endif
        end
      end
      S_EX: begin
        if (sbtype) begin
          pc_we   = 1'b1;
          npc_sel = Zero ? NPC_BRANCH : NPC_PLUS4;
          state_d = S_IF;
        end else if (MemRead_d || MemWrite_d) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite_d;
        if (dmem_ack) begin
          if (MemWrite_d) begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = RegWrite_d;
        pc_we   = 1'b1;
        npc_sel = i_jal ? NPC_JUMP : (i_jalr ? NPC_JALR : NPC_PLUS4);
        state_d = S_IF;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
    instret_d = pc_we ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_mc_seq.sv
// Directed bench for mc_seq: per-cycle strobe vectors, latencies and instret checked against hand-derived values.
module tb_mc_seq;
  logic        clk, rst;
  logic [6:0]  Op;
  logic        RegWrite_d, MemWrite_d, MemRead_d, sbtype, i_jal, i_jalr, Zero;
  logic        imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, mdr_we, reg_we, pc_we;
  logic [2:0]  npc_sel, state;
  logic [31:0] instret;
  logic        illegal;

  int          n_total = 0;
  int          n_pass  = 0;
  int          last_lat;
  int          bad_rst = 0;
  logic [31:0] exp_instret = 32'd0;

  mc_seq dut (
    .clk(clk), .rst(rst), .Op(Op), .RegWrite_d(RegWrite_d), .MemWrite_d(MemWrite_d),
    .MemRead_d(MemRead_d), .sbtype(sbtype), .i_jal(i_jal), .i_jalr(i_jalr), .Zero(Zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .mdr_we(mdr_we), .reg_we(reg_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .state(state), .instret(instret), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk)
    if (rst && (pc_we || reg_we || imem_req || dmem_req || ir_we || mdr_we)) bad_rst++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vector per cycle: {state, imem_req, dmem_req, dmem_we, ir_we, mdr_we, reg_we, pc_we, npc_sel}.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic ireq, input logic dreq,
                            input logic dwe, input logic irwe, input logic mdrwe, input logic regwe,
                            input logic pcwe, input logic [2:0] npc);
    logic [12:0] got, exp;
    got = {state, imem_req, dmem_req, dmem_req ? dmem_we : 1'b0, ir_we, mdr_we, reg_we, pc_we,
           pc_we ? npc_sel : 3'b000};
    exp = {st, ireq, dreq, dreq ? dwe : 1'b0, irwe, mdrwe, regwe, pcwe, pcwe ? npc : 3'b000};
    chk(tag, {19'd0, got}, {19'd0, exp});
  endtask

  // Entered at posedge+1 of an IF cycle; leaves at posedge+1 of the next IF cycle.
  task automatic run(input string tag, input logic [6:0] op, input logic rw, input logic mw,
                     input logic mr, input logic sb, input logic jal, input logic jalr,
                     input logic z, input int iwait, input int dwait, input logic noise);
    int cyc;
    cyc = 0;
    Op = op; RegWrite_d = rw; MemWrite_d = mw; MemRead_d = mr;
    sbtype = sb; i_jal = jal; i_jalr = jalr; Zero = z;
    for (int w = 0; w <= iwait; w++) begin
      imem_ack = (w == iwait); dmem_ack = noise;
      @(negedge clk); cyc++;
      expect_cyc({tag, "/IF"}, 3'd0, 1'b1, 1'b0, 1'b0, (w == iwait), 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
    end
    imem_ack = noise;
    @(negedge clk); cyc++;
    expect_cyc({tag, "/ID"}, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    @(negedge clk); cyc++;
    if (sb) begin
      expect_cyc({tag, "/EX"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, z ? 3'b001 : 3'b000);
      tick();
      exp_instret++;
    end else begin
      expect_cyc({tag, "/EX"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
      if (mr || mw) begin
        for (int w = 0; w <= dwait; w++) begin
          dmem_ack = (w == dwait);
          @(negedge clk); cyc++;
          expect_cyc({tag, "/MEM"}, 3'd3, 1'b0, 1'b1, mw, 1'b0, (w == dwait) && !mw, 1'b0,
                     (w == dwait) && mw, 3'd0);
          tick();
        end
        dmem_ack = noise;
      end
      if (!mw) begin
        @(negedge clk); cyc++;
        expect_cyc({tag, "/WB"}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rw, 1'b1,
                   jal ? 3'b010 : (jalr ? 3'b100 : 3'b000));
        tick();
      end
      exp_instret++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    last_lat = cyc;
    chk({tag, "/instret"}, instret, exp_instret);
  endtask

  // Drops rst at posedge+1 and checks the quiet RST cycle; returns in the first IF cycle.
  task automatic release_rst(input string tag);
    rst = 1'b0;
    @(negedge clk);
    expect_cyc({tag, "/RST"}, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    exp_instret = 32'd0;
  endtask

  initial begin
    rst = 1'b1; Op = 7'd0; RegWrite_d = 1'b0; MemWrite_d = 1'b0; MemRead_d = 1'b0;
    sbtype = 1'b0; i_jal = 1'b0; i_jalr = 1'b0; Zero = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    expect_cyc("reset", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    release_rst("boot");

    run("add", 7'b0110011, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("add_lat", last_lat, 4);
    run("lw_d3", 7'b0000011, 1, 0, 1, 0, 0, 0, 0, 0, 3, 0);
    chk("lw_lat", last_lat, 8);
    run("lw", 7'b0000011, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("lw1_lat", last_lat, 5);
    run("sw_i2", 7'b0100011, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    chk("sw_lat", last_lat, 6);
    run("beq_t", 7'b1100011, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    chk("beq_lat", last_lat, 3);
    run("beq_nt", 7'b1100011, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    run("jalr", 7'b1100111, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    run("jal", 7'b1101111, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    run("lui_noise", 7'b0110111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run("addi_norw", 7'b0010011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    force dut.instret_q = 32'hFFFF_FFFF;
    #2;
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    run("wrap", 7'b1100011, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    chk("wrap_zero", instret, 32'd0);

    Op = 7'b0000011; RegWrite_d = 1'b1; MemRead_d = 1'b1; MemWrite_d = 1'b0;
    sbtype = 1'b0; i_jal = 1'b0; i_jalr = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    expect_cyc("rstmem/MEM", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    #1;
    dmem_ack = 1'b1;
    rst = 1'b1;
    #1;
    expect_cyc("rstmem/abort", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("rstmem/instret", instret, 32'd0);
    repeat (2) tick();
    dmem_ack = 1'b0;
    release_rst("rstmem");
    chk("rst_strobes", bad_rst, 0);
    run("add_after_rst", 7'b0110011, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    Op = 7'b0000000; RegWrite_d = 1'b0; MemRead_d = 1'b0; MemWrite_d = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    expect_cyc("ill/IF", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
`ifdef MC_ILLEGAL_TRAP_EN
    expect_cyc("ill/ID", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      expect_cyc("ill/TRAP", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("ill/flag", {31'd0, illegal}, 32'd1);
    chk("ill/instret", instret, exp_instret);
`else
    expect_cyc("ill/ID", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    exp_instret++;
    chk("ill/instret", instret, exp_instret);
    chk("ill/flag", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    expect_cyc("ill/nextIF", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
`endif
    rst = 1'b1;
    tick();
    chk("ill/cleared", {31'd0, illegal}, 32'd0);
    release_rst("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
